// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the MEM-stage data-memory access controller:
// FSM state encoding and default timeout / fault-data constants.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10
    } state_e;

    localparam int unsigned DEF_TIMEOUT_CYCLES = 15;
    localparam logic [31:0] DEF_FAULT_DATA     = 32'h0000_0000;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Access watchdog: counts enabled cycles and flags the last permitted cycle
// (count == TIMEOUT_CYCLES-1) so the controller can abort on that edge.
module mem_timeout_ctr
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = 8'd0;
        end else if (enable_i) begin
            count_d = count_q + 8'd1;
        end
    end

    // NOTE: sequential state is updated with <= so every flop samples the
    // pre-edge values of the others; blocking here would create races.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = enable_i && (count_q == LAST_COUNT);

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory sequencer: issues one req/ack transaction per load or
// store, stalls the front of the pipeline and bubbles MEM/WB until it completes.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter logic [31:0] FAULT_DATA     = DEF_FAULT_DATA
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        M_MemRead,
    input  logic        M_MemWrite,
    input  logic [31:0] M_Addr,
    input  logic [31:0] M_WriteData,
    output logic        DM_Req,
    output logic        DM_We,
    output logic [31:0] DM_Addr,
    output logic [31:0] DM_WData,
    input  logic        DM_Ack,
    input  logic [31:0] DM_RData,
    output logic        Stall,
    output logic        WB_Bubble,
    output logic [31:0] MemData_Out,
    output logic        Fault
);

    state_e      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        fault_q, fault_d;

    logic        mem_req;
    logic        stall_raw;
    logic        ctr_clear;
    logic        ctr_expire;

    assign mem_req = M_MemRead | M_MemWrite;

    mem_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk_i   (Clk),
        .rst_n_i (Rst_n),
        .clear_i (ctr_clear),
        .enable_i(state_q == ACCESS),
        .expire_o(ctr_expire)
    );

    // NOTE: every output of this block is given a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        fault_d   = fault_q;
        stall_raw = 1'b0;
        ctr_clear = 1'b0;

        case (state_q)
            IDLE: begin
                stall_raw = mem_req;
                if (mem_req) begin
                    addr_d  = M_Addr;
                    wdata_d = M_WriteData;
                    we_d    = M_MemWrite;
                    req_d   = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                stall_raw = 1'b1;
                // Ack takes priority over an expiry in the same cycle.
                if (DM_Ack) begin
                    if (!we_q) rdata_d = DM_RData;
                    req_d     = 1'b0;
                    we_d      = 1'b0;
                    ctr_clear = 1'b1;
                    state_d   = DONE;
                end else if (ctr_expire) begin
                    if (!we_q) rdata_d = FAULT_DATA;
                    fault_d   = 1'b1;
                    req_d     = 1'b0;
                    we_d      = 1'b0;
                    ctr_clear = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                // EX/MEM still holds the finished access; do not re-issue it.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end

    // The IDLE stall is combinational from EX/MEM, so gate it with reset.
    assign Stall       = Rst_n & stall_raw;
    assign WB_Bubble   = Rst_n & stall_raw;
    assign DM_Req      = req_q;
    assign DM_We       = we_q;
    assign DM_Addr     = addr_q;
    assign DM_WData    = wdata_q;
    assign MemData_Out = rdata_q;
    assign Fault       = fault_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized self-checking bench for mem_access_ctrl against a
// transaction-level model of stall length, request length and read-data result.
module tb_mem_access_ctrl;
    import mem_ctrl_pkg::*;

    localparam int unsigned T        = 4;
    localparam logic [31:0] TB_FAULT = DEF_FAULT_DATA ^ 32'hDEAD_BEEF;

    logic        Clk;
    logic        Rst_n;
    logic        M_MemRead;
    logic        M_MemWrite;
    logic [31:0] M_Addr;
    logic [31:0] M_WriteData;
    logic        DM_Req;
    logic        DM_We;
    logic [31:0] DM_Addr;
    logic [31:0] DM_WData;
    logic        DM_Ack;
    logic [31:0] DM_RData;
    logic        Stall;
    logic        WB_Bubble;
    logic [31:0] MemData_Out;
    logic        Fault;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] model_md;
    logic        model_fault;

    mem_access_ctrl #(
        .TIMEOUT_CYCLES(T),
        .FAULT_DATA    (TB_FAULT)
    ) dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .M_MemRead  (M_MemRead),
        .M_MemWrite (M_MemWrite),
        .M_Addr     (M_Addr),
        .M_WriteData(M_WriteData),
        .DM_Req     (DM_Req),
        .DM_We      (DM_We),
        .DM_Addr    (DM_Addr),
        .DM_WData   (DM_WData),
        .DM_Ack     (DM_Ack),
        .DM_RData   (DM_RData),
        .Stall      (Stall),
        .WB_Bubble  (WB_Bubble),
        .MemData_Out(MemData_Out),
        .Fault      (Fault)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Runs one memory instruction starting in an IDLE cycle (called just after
    // a falling edge). k = ACCESS cycle carrying the ack; 0 or >T = no ack.
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wd, input int k, input logic [31:0] rdata);
        int  stalls;
        int  reqs;
        bit  acked;
        bit  is_read;
        stalls  = 0;
        reqs    = 0;
        acked   = (k >= 1) && (k <= int'(T));
        is_read = rd && !wr;

        M_MemRead   = rd;
        M_MemWrite  = wr;
        M_Addr      = addr;
        M_WriteData = wd;
        #1;
        check("idle_no_outstanding_req", {31'd0, DM_Req}, 32'd0);
        check("idle_stall", {31'd0, Stall}, 32'd1);
        check("idle_bubble", {31'd0, WB_Bubble}, 32'd1);
        if (Stall) stalls++;

        @(negedge Clk);
        for (int c = 1; c <= int'(T); c++) begin
            #1;
            check("acc_req", {31'd0, DM_Req}, 32'd1);
            check("acc_we", {31'd0, DM_We}, {31'd0, wr});
            check("acc_addr", DM_Addr, addr);
            check("acc_wdata", DM_WData, wd);
            check("acc_stall", {31'd0, Stall}, 32'd1);
            check("acc_bubble", {31'd0, WB_Bubble}, 32'd1);
            if (Stall) stalls++;
            if (DM_Req) reqs++;
            if (c == k) begin
                DM_Ack   = 1'b1;
                DM_RData = rdata;
            end
            @(negedge Clk);
            DM_Ack   = 1'b0;
            DM_RData = $urandom;
            if (c == k) break;
        end

        if (acked) begin
            if (is_read) model_md = rdata;
        end else begin
            model_fault = 1'b1;
            if (is_read) model_md = TB_FAULT;
        end

        // DONE: EX/MEM contents are not acted on; drive junk to prove it.
        M_MemRead   = 1'($urandom);
        M_MemWrite  = 1'($urandom);
        M_Addr      = $urandom;
        M_WriteData = $urandom;
        #1;
        check("done_stall", {31'd0, Stall}, 32'd0);
        check("done_bubble", {31'd0, WB_Bubble}, 32'd0);
        check("done_req", {31'd0, DM_Req}, 32'd0);
        check("done_memdata", MemData_Out, model_md);
        check("done_fault", {31'd0, Fault}, {31'd0, model_fault});
        check("stall_cycles", stalls, acked ? k + 1 : int'(T) + 1);
        check("req_cycles", reqs, acked ? k : int'(T));

        @(negedge Clk);
        M_MemRead  = 1'b0;
        M_MemWrite = 1'b0;
    endtask

    task automatic do_alu_op();
        M_MemRead   = 1'b0;
        M_MemWrite  = 1'b0;
        M_Addr      = $urandom;
        M_WriteData = $urandom;
        #1;
        check("alu_stall", {31'd0, Stall}, 32'd0);
        check("alu_bubble", {31'd0, WB_Bubble}, 32'd0);
        @(negedge Clk);
        #1;
        check("alu_no_req", {31'd0, DM_Req}, 32'd0);
        check("alu_memdata", MemData_Out, model_md);
    endtask

    task automatic pulse_reset();
        #2;
        Rst_n = 1'b0;
        model_md    = 32'd0;
        model_fault = 1'b0;
        #1;
        check("rst_req", {31'd0, DM_Req}, 32'd0);
        check("rst_we", {31'd0, DM_We}, 32'd0);
        check("rst_addr", DM_Addr, 32'd0);
        check("rst_wdata", DM_WData, 32'd0);
        check("rst_stall", {31'd0, Stall}, 32'd0);
        check("rst_bubble", {31'd0, WB_Bubble}, 32'd0);
        check("rst_memdata", MemData_Out, 32'd0);
        check("rst_fault", {31'd0, Fault}, 32'd0);
        M_MemRead  = 1'b0;
        M_MemWrite = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b1;
    endtask

    initial begin
        Rst_n       = 1'b0;
        M_MemRead   = 1'b1;
        M_MemWrite  = 1'b0;
        M_Addr      = 32'h1;
        M_WriteData = 32'h2;
        DM_Ack      = 1'b0;
        DM_RData    = 32'd0;
        model_md    = 32'd0;
        model_fault = 1'b0;

        @(negedge Clk);
        pulse_reset();

        // Read, 1-cycle memory
        do_access(1'b1, 1'b0, 32'h40, 32'h0, 1, 32'h1234_5678);
        // Store, 3-cycle memory
        do_access(1'b0, 1'b1, 32'h80, 32'hCAFE_F00D, 3, $urandom);
        // Ack coincides with expiry
        do_access(1'b1, 1'b0, 32'h44, 32'h0, int'(T), 32'hA5A5_A5A5);
        // Read timeout, then Fault must stay sticky
        do_access(1'b1, 1'b0, 32'h48, 32'h0, 0, $urandom);
        do_access(1'b1, 1'b0, 32'h4C, 32'h0, 1, 32'h0BAD_F00D);
        do_alu_op();
        do_access(1'b0, 1'b1, 32'h50, 32'h1111_2222, 2, $urandom);

        // Reset in the 2nd ACCESS cycle, then a stale ack
        M_MemRead = 1'b1;
        M_Addr    = 32'h60;
        @(negedge Clk);
        @(negedge Clk);
        pulse_reset();
        DM_Ack   = 1'b1;
        DM_RData = 32'h7777_7777;
        @(negedge Clk);
        DM_Ack = 1'b0;
        #1;
        check("late_ack_req", {31'd0, DM_Req}, 32'd0);
        check("late_ack_stall", {31'd0, Stall}, 32'd0);
        check("late_ack_memdata", MemData_Out, 32'd0);
        @(negedge Clk);

        // Back-to-back mixed traffic, 2-cycle memory
        do_access(1'b1, 1'b0, 32'h100, 32'h0, 2, 32'h0000_0001);
        do_access(1'b1, 1'b0, 32'h104, 32'h0, 2, 32'h0000_0002);
        do_alu_op();
        do_access(1'b0, 1'b1, 32'h108, 32'hFEED_BEEF, 2, $urandom);
        // Load+store together: write only, read data untouched
        do_access(1'b1, 1'b1, 32'h10C, 32'h5555_AAAA, 2, 32'h9999_9999);

        // Randomized traffic including stray acks while idle
        for (int i = 0; i < 60; i++) begin
            int sel;
            int k;
            sel = $urandom_range(0, 4);
            k   = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, T + 1);
            case (sel)
                0: do_alu_op();
                1: do_access(1'b1, 1'b0, $urandom, $urandom, k, $urandom);
                2: do_access(1'b0, 1'b1, $urandom, $urandom, k, $urandom);
                3: do_access(1'b1, 1'b1, $urandom, $urandom, k, $urandom);
                default: begin
                    DM_Ack   = 1'b1;
                    DM_RData = $urandom;
                    do_alu_op();
                    DM_Ack = 1'b0;
                end
            endcase
            if (i == 30) pulse_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
